// File: rtl/led_ripple_ctrl.sv
// led_ripple_ctrl
//   Drives a one-hot LED "ripple" at a programmable step rate. A prescaler
//   counts enabled cycles. When the count reaches step_div, a step event
//   fires and the lit LED moves according to mode:
//     00 rotate-up, 01 rotate-down, 10 bounce (ping-pong), 11 hold.
//
// Ports
//   clk       single clock, rising edge
//   reset     synchronous, active-high; overrides enable
//   enable    allows the prescaler and the pattern to advance
//   mode      pattern select (see above); sampled on step events only
//   step_div  step period in cycles minus one
//   led       registered one-hot LED drive, always 1 << pos
//   pos       registered index of the lit LED
//   tick      one-cycle registered pulse on every step event
//   wrap      one-cycle registered pulse on a wrap or bounce turnaround
module led_ripple_ctrl #(
  parameter int NUM_LEDS  = 8,
  parameter int DIV_WIDTH = 24,
  parameter int POS_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] step_div,
  output logic [NUM_LEDS-1:0]  led,
  output logic [POS_WIDTH-1:0] pos,
  output logic                 tick,
  output logic                 wrap
);

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  localparam logic [POS_WIDTH-1:0] POS_FIRST  = '0;
  localparam logic [POS_WIDTH-1:0] POS_ONE    = POS_WIDTH'(1);
  localparam logic [POS_WIDTH-1:0] POS_LAST   = POS_WIDTH'(NUM_LEDS - 1);
  localparam logic [POS_WIDTH-1:0] POS_PENULT = POS_WIDTH'(NUM_LEDS - 2);
  localparam logic [NUM_LEDS-1:0]  LED_FIRST  = NUM_LEDS'(1);

  logic [DIV_WIDTH-1:0] count;
  dir_t                 dir;
  dir_t                 dir_nxt;
  logic [POS_WIDTH-1:0] pos_nxt;
  logic                 wrap_nxt;
  logic                 step;

  // A >= compare means lowering step_div below the running count forces a
  // step on the next enabled cycle instead of waiting for a counter wrap.
  // The increment only happens while count < step_div, so it cannot overflow.
  assign step = enable && (count >= step_div);

  // Where the pattern would move on a step event.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    pos_nxt  = pos;
    dir_nxt  = dir;
    wrap_nxt = 1'b0;
    case (mode_t'(mode))
      MODE_UP: begin
        dir_nxt = UP;
        if (pos == POS_LAST) begin
          pos_nxt  = POS_FIRST;
          wrap_nxt = 1'b1;
        end else begin
          pos_nxt = pos + POS_ONE;
        end
      end
      MODE_DOWN: begin
        dir_nxt = DOWN;
        if (pos == POS_FIRST) begin
          pos_nxt  = POS_LAST;
          wrap_nxt = 1'b1;
        end else begin
          pos_nxt = pos - POS_ONE;
        end
      end
      MODE_BOUNCE: begin
        // Turnaround moves straight to the neighbour: no dwell at either end.
        // The same rule also covers entering bounce already at an end.
        if (dir == UP) begin
          if (pos == POS_LAST) begin
            pos_nxt  = POS_PENULT;
            dir_nxt  = DOWN;
            wrap_nxt = 1'b1;
          end else begin
            pos_nxt = pos + POS_ONE;
          end
        end else begin
          if (pos == POS_FIRST) begin
            pos_nxt  = POS_ONE;
            dir_nxt  = UP;
            wrap_nxt = 1'b1;
          end else begin
            pos_nxt = pos - POS_ONE;
          end
        end
      end
      default: begin
        // MODE_HOLD: tick still pulses, but position and direction stay put.
      end
    endcase
  end

  // Prescaler, direction FSM and all registered outputs.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      pos   <= POS_FIRST;
      led   <= LED_FIRST;
      dir   <= UP;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (step) begin
        count <= '0;
        tick  <= 1'b1;
        wrap  <= wrap_nxt;
        pos   <= pos_nxt;
        dir   <= dir_nxt;
        led   <= LED_FIRST << pos_nxt;
      end else if (enable) begin
        count <= count + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_ripple_ctrl.sv
// Scoreboard bench for led_ripple_ctrl (NUM_LEDS=8).
// The stimulus process pushes hand-computed step events (absolute clock
// edge, led, pos, wrap) into a queue; the monitor pops one entry per tick
// and also flags ticks nobody expected and expected ticks that never came.
module tb_led_ripple_ctrl;

  localparam int N  = 8;
  localparam int DW = 24;
  localparam int PW = 3;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          enable   = 1'b0;
  logic [1:0]    mode     = 2'b00;
  logic [DW-1:0] step_div = '0;
  logic [N-1:0]  led;
  logic [PW-1:0] pos;
  logic          tick;
  logic          wrap;

  led_ripple_ctrl #(
    .NUM_LEDS (N),
    .DIV_WIDTH(DW),
    .POS_WIDTH(PW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .mode    (mode),
    .step_div(step_div),
    .led     (led),
    .pos     (pos),
    .tick    (tick),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [7:0] led;
    logic [2:0] pos;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   base   = 0;

  logic [7:0] led_a [9] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
  logic [2:0] pos_c [23] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4,
                             3'd3, 3'd2, 3'd1, 3'd0, 3'd1,
                             3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5};
  logic       wrap_c [23] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1,
                              0, 0, 0, 0, 0, 0, 1, 0};

  // Edge counter: value seen after the k-th rising edge is k.
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int at, input logic [7:0] l, input logic [2:0] p, input logic w);
    exp_t e;
    e.at   = at;
    e.led  = l;
    e.pos  = p;
    e.wrap = w;
    sb.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].at < cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_tick: no tick at edge %0d (led 0x%0h pos %0d expected)",
                 e.at, e.led, e.pos);
      end
      if (tick) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick: tick at edge %0d with led 0x%0h pos %0d", cyc, led, pos);
        end else begin
          e = sb.pop_front();
          check("tick_edge", cyc, e.at);
          check("step_led", led, e.led);
          check("step_pos", pos, e.pos);
          check("step_wrap", wrap, e.wrap);
        end
      end else begin
        check("idle_wrap", wrap, 0);
      end
    end
  end

  // Stimulus. Inputs change on falling edges; base is the edge count just
  // before the next rising edge, so base+1 is that edge.
  initial begin : stimulus
    wait_neg(2);
    check("rst_led", led, 8'h01);
    check("rst_pos", pos, 0);
    check("rst_tick", tick, 0);
    check("rst_wrap", wrap, 0);

    // Reset dominates enable.
    enable   = 1'b1;
    mode     = 2'b00;
    step_div = 0;
    wait_neg(2);
    check("rst_over_en_led", led, 8'h01);
    check("rst_over_en_pos", pos, 0);

    // Rotate-up, step every cycle.
    base  = cyc;
    reset = 1'b0;
    for (int i = 0; i < 9; i++) push(base + i + 1, led_a[i], 3'((i + 1) % 8), i == 7);
    wait_neg(9);

    // Rotate-down, step every 4 cycles.
    reset = 1'b1;
    wait_neg(1);
    check("rst2_led", led, 8'h01);
    base     = cyc;
    reset    = 1'b0;
    mode     = 2'b01;
    step_div = 3;
    push(base + 4,  8'h80, 3'd7, 1'b1);
    push(base + 8,  8'h40, 3'd6, 1'b0);
    push(base + 12, 8'h20, 3'd5, 1'b0);
    wait_neg(12);

    // Bounce, step every cycle, ending at pos 5 moving down.
    reset = 1'b1;
    wait_neg(1);
    base     = cyc;
    reset    = 1'b0;
    mode     = 2'b10;
    step_div = 0;
    for (int i = 0; i < 23; i++) push(base + i + 1, 8'h01 << pos_c[i], pos_c[i], wrap_c[i]);
    wait_neg(23);
    check("pre_reset_pos", pos, 5);

    // One-cycle reset mid-bounce; restart counting with step_div = 2.
    reset    = 1'b1;
    step_div = 2;
    wait_neg(1);
    check("midbounce_rst_led", led, 8'h01);
    check("midbounce_rst_pos", pos, 0);
    base  = cyc;
    reset = 1'b0;
    push(base + 3, 8'h02, 3'd1, 1'b0);
    push(base + 6, 8'h04, 3'd2, 1'b0);
    wait_neg(6);

    // Rotate-down into pos 0, then bounce entered moving DOWN at the end.
    base     = cyc;
    mode     = 2'b01;
    step_div = 0;
    push(base + 1, 8'h02, 3'd1, 1'b0);
    push(base + 2, 8'h01, 3'd0, 1'b0);
    wait_neg(2);
    base = cyc;
    mode = 2'b10;
    push(base + 1, 8'h02, 3'd1, 1'b1);
    push(base + 2, 8'h04, 3'd2, 1'b0);
    wait_neg(2);

    // step_div lowered below the running count.
    reset = 1'b1;
    wait_neg(1);
    base     = cyc;
    reset    = 1'b0;
    mode     = 2'b00;
    step_div = 9;
    push(base + 7,  8'h02, 3'd1, 1'b0);
    push(base + 10, 8'h04, 3'd2, 1'b0);
    push(base + 13, 8'h08, 3'd3, 1'b0);
    wait_neg(6);
    step_div = 2;
    wait_neg(7);

    // Disabled mid-period: everything frozen (count sits at 1).
    wait_neg(1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_neg(1);
      check("frozen_led", led, 8'h08);
      check("frozen_pos", pos, 3);
      check("frozen_tick", tick, 0);
    end

    // Hold: prescaler resumes from count 1, tick keeps pulsing, LED stays.
    base   = cyc;
    enable = 1'b1;
    mode   = 2'b11;
    push(base + 2, 8'h08, 3'd3, 1'b0);
    push(base + 5, 8'h08, 3'd3, 1'b0);
    push(base + 8, 8'h08, 3'd3, 1'b0);
    wait_neg(9);
    check("hold_led", led, 8'h08);

    // Mode change mid-period keeps the prescaler phase (count is 1 here).
    base = cyc;
    mode = 2'b00;
    push(base + 2, 8'h10, 3'd4, 1'b0);
    wait_neg(4);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
